// File: rtl/io_pkg.sv
// io_pkg
// Shared definitions for the CPU-facing IO responder: the controller state
// encoding, the command codes seen on cmd, the largest value the three-digit
// display can show, and the number of shift-and-add-3 steps needed for a
// 10-bit binary value.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        CONVERT    = 2'd2,
        RESPOND    = 2'd3
    } state_t;

    localparam logic [1:0]  CMD_IN      = 2'b01;
    localparam logic [1:0]  CMD_OUT     = 2'b10;
    localparam logic [31:0] MAX_DISPLAY = 32'd999;
    localparam logic [3:0]  CONV_STEPS  = 4'd10;

endpackage

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter
// Iterative binary-to-BCD converter (double dabble), one shift-and-add-3 step
// per clock on a 12-bit BCD register.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               load value and begin a conversion
//   value[9:0]          binary value to convert (0..999)
//   hundreds/tens/ones  BCD digits, valid when done is high
//   done                one-cycle pulse, high the cycle after the last step
module bcd_seq_converter
    import io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] value,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       done
);

    logic [9:0]  shiftBin;
    logic [11:0] bcd;
    logic [11:0] bcdAdj;
    logic [3:0]  stepCnt;
    logic        running;

    // Any digit of 5 or more gets +3 so the following left shift carries
    // correctly into the next decade.
    function automatic logic [11:0] addThree(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcdAdj   = addThree(bcd);
    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            running  <= 1'b0;
            done     <= 1'b0;
            stepCnt  <= '0;
            shiftBin <= '0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shiftBin <= value;
                bcd      <= '0;
                stepCnt  <= '0;
                running  <= 1'b1;
            end else if (running) begin
                bcd      <= {bcdAdj[10:0], shiftBin[9]};
                shiftBin <= {shiftBin[8:0], 1'b0};
                stepCnt  <= stepCnt + 4'd1;
                if (stepCnt == CONV_STEPS - 4'd1) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// io_responder
// Services CPU IN/OUT requests for a simple board: IN waits for a button
// press and returns the switches, OUT shows a value on three BCD digits.
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   req, cmd[1:0], wdata[31:0]   CPU request (cmd 01 = IN, 10 = OUT, else NOP)
//   botao, switches[3:0]         debounced button level and data switches
//   ack                          one-cycle completion pulse
//   rdata[31:0]                  result of the last completed IN
//   busy, waiting_in             controller not idle / waiting for a press
//   timeout                      set in the ack cycle of a timed-out IN
//   overflow                     last OUT value was above 999
//   unidade, dezena, centena     BCD display digits
// IN_TIMEOUT: cycles to wait for a press before IN gives up (0 = forever).
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned IN_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  cmd,
    input  logic [31:0] wdata,
    input  logic        botao,
    input  logic [3:0]  switches,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        waiting_in,
    output logic        timeout,
    output logic        overflow,
    output logic [3:0]  unidade,
    output logic [3:0]  dezena,
    output logic [3:0]  centena
);

    state_t      state;
    logic        botaoQ;
    logic        botaoPrev;
    logic        rise;
    logic        respondOvf;
    logic        outOfRange;
    logic        convStart;
    logic        convDone;
    logic [3:0]  convHund;
    logic [3:0]  convTens;
    logic [3:0]  convOnes;
    logic [31:0] waitCnt;

    // The edge detector runs in every state, so a button already held when
    // IN is accepted shows no rising edge afterwards.
    assign rise       = botaoQ & ~botaoPrev;
    assign outOfRange = wdata > MAX_DISPLAY;
    // The converter captures wdata on the same edge the FSM accepts the OUT.
    assign convStart  = (state == IDLE) && req && !ack && (cmd == CMD_OUT) && !outOfRange;

    bcd_seq_converter conv (
        .clk      (clk),
        .reset    (reset),
        .start    (convStart),
        .value    (wdata[9:0]),
        .hundreds (convHund),
        .tens     (convTens),
        .ones     (convOnes),
        .done     (convDone)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ack        <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            waiting_in <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            unidade    <= '0;
            dezena     <= '0;
            centena    <= '0;
            waitCnt    <= '0;
            respondOvf <= 1'b0;
            botaoQ     <= botao;
            botaoPrev  <= botao;
        end else begin
            botaoQ    <= botao;
            botaoPrev <= botaoQ;
            ack       <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    // ack still high means the previous request is only now
                    // completing; the CPU has not had a chance to drop req.
                    if (req && !ack) begin
                        busy    <= 1'b1;
                        waitCnt <= '0;
                        if (cmd == CMD_IN) begin
                            state      <= WAIT_PRESS;
                            waiting_in <= 1'b1;
                        end else if (cmd == CMD_OUT && !outOfRange) begin
                            state <= CONVERT;
                        end else begin
                            state      <= RESPOND;
                            respondOvf <= (cmd == CMD_OUT);
                        end
                    end
                end
                WAIT_PRESS: begin
                    // A press seen in the same cycle as the timeout wins.
                    if (rise) begin
                        rdata      <= {28'b0, switches};
                        ack        <= 1'b1;
                        busy       <= 1'b0;
                        waiting_in <= 1'b0;
                        state      <= IDLE;
                    end else if (IN_TIMEOUT != 0 && waitCnt == IN_TIMEOUT) begin
                        rdata      <= '0;
                        ack        <= 1'b1;
                        timeout    <= 1'b1;
                        busy       <= 1'b0;
                        waiting_in <= 1'b0;
                        state      <= IDLE;
                    end else if (IN_TIMEOUT != 0) begin
                        waitCnt <= waitCnt + 32'd1;
                    end
                end
                CONVERT: begin
                    // Digits stay frozen until the conversion is complete.
                    if (convDone) begin
                        centena  <= convHund;
                        dezena   <= convTens;
                        unidade  <= convOnes;
                        overflow <= 1'b0;
                        ack      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RESPOND: begin
                    if (respondOvf) begin
                        centena  <= 4'd9;
                        dezena   <= 4'd9;
                        unidade  <= 4'd9;
                        overflow <= 1'b1;
                    end
                    ack   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder
// Two responders share clock and reset: dut0 waits forever for a press,
// dut1 gives up after 8 cycles. Requests push their expected completion into
// a per-DUT queue; a monitor pops and compares whenever ack is seen.
module tb_io_responder;

    typedef struct {
        int          ackEdge;
        logic [31:0] rdata;
        logic [3:0]  c;
        logic [3:0]  d;
        logic [3:0]  u;
        logic        ovf;
        logic        tmo;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        req[2];
    logic [1:0]  cmd[2];
    logic [31:0] wdata[2];
    logic        botao[2];
    logic [3:0]  switches[2];
    logic        ack[2];
    logic [31:0] rdata[2];
    logic        busy[2];
    logic        waitingIn[2];
    logic        timeoutO[2];
    logic        overflow[2];
    logic [3:0]  unidade[2];
    logic [3:0]  dezena[2];
    logic [3:0]  centena[2];

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    // Reference state: what each DUT's outputs should hold after its last ack.
    logic [31:0] mRdata[2];
    logic [3:0]  mC[2];
    logic [3:0]  mD[2];
    logic [3:0]  mU[2];
    logic        mOvf[2];
    logic        ackPrev[2];

    io_responder #(.IN_TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .cmd(cmd[0]), .wdata(wdata[0]),
        .botao(botao[0]), .switches(switches[0]), .ack(ack[0]), .rdata(rdata[0]),
        .busy(busy[0]), .waiting_in(waitingIn[0]), .timeout(timeoutO[0]),
        .overflow(overflow[0]), .unidade(unidade[0]), .dezena(dezena[0]), .centena(centena[0])
    );

    io_responder #(.IN_TIMEOUT(8)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .cmd(cmd[1]), .wdata(wdata[1]),
        .botao(botao[1]), .switches(switches[1]), .ack(ack[1]), .rdata(rdata[1]),
        .busy(busy[1]), .waiting_in(waitingIn[1]), .timeout(timeoutO[1]),
        .overflow(overflow[1]), .unidade(unidade[1]), .dezena(dezena[1]), .centena(centena[1])
    );

    always #5 clk = ~clk;

    // cyc equals the index of the next posedge when read at a negedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h (edge %0d)", d, name, act, exp, cyc - 1);
        end
    endtask

    task automatic pushExp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic dropExp(input int d);
        if (d == 0 && q0.size() > 0) void'(q0.pop_front());
        if (d == 1 && q1.size() > 0) void'(q1.pop_front());
    endtask

    // After acceptance the request fields are noise and req may be dropped.
    task automatic scramble(input int d);
        if ($urandom_range(0, 3) == 0) req[d] = 1'b0;
        cmd[d]   = 2'($urandom);
        wdata[d] = $urandom;
    endtask

    function automatic logic botaoAt(input int k, input bit pre, input int rel, input int pk);
        if (pre && k < rel) return 1'b1;
        return (k >= pk) ? 1'b1 : 1'b0;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d]) begin
                exp_t e;
                bit   have;
                chk(d, "ack_back_to_back", 32'(ackPrev[d]), 32'd0);
                have = 1'b0;
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    checks++;
                    failures++;
                    $display("FAIL dut%0d unexpected_ack: got ack at edge %0d expected none", d, cyc - 1);
                end else begin
                    chk(d, "ack_edge", 32'(cyc - 1), 32'(e.ackEdge));
                    chk(d, "rdata", rdata[d], e.rdata);
                    chk(d, "digits", 32'({centena[d], dezena[d], unidade[d]}), 32'({e.c, e.d, e.u}));
                    chk(d, "overflow", 32'(overflow[d]), 32'(e.ovf));
                    chk(d, "timeout", 32'(timeoutO[d]), 32'(e.tmo));
                    chk(d, "busy_at_ack", 32'(busy[d]), 32'd0);
                    chk(d, "waiting_at_ack", 32'(waitingIn[d]), 32'd0);
                end
            end
            ackPrev[d] <= ack[d];
        end
    end

    // OUT or NOP request.
    task automatic doReq(input int d, input logic [1:0] c, input logic [31:0] v);
        exp_t e;
        int   e0;
        bit   seen;
        logic [11:0] oldDigits;
        @(negedge clk);
        e0 = cyc;
        req[d] = 1'b1;
        cmd[d] = c;
        wdata[d] = v;
        oldDigits = {mC[d], mD[d], mU[d]};
        if (c == 2'b10 && v > 999) begin
            mC[d] = 4'd9; mD[d] = 4'd9; mU[d] = 4'd9; mOvf[d] = 1'b1;
            e.ackEdge = e0 + 1;
        end else if (c == 2'b10) begin
            mC[d] = 4'(v / 100); mD[d] = 4'((v / 10) % 10); mU[d] = 4'(v % 10); mOvf[d] = 1'b0;
            e.ackEdge = e0 + 11;
        end else begin
            e.ackEdge = e0 + 1;
        end
        e.rdata = mRdata[d]; e.c = mC[d]; e.d = mD[d]; e.u = mU[d]; e.ovf = mOvf[d]; e.tmo = 1'b0;
        pushExp(d, e);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (ack[d]) seen = 1'b1;
            else begin
                chk(d, "busy_during_op", 32'(busy[d]), 32'd1);
                chk(d, "digits_hold", 32'({centena[d], dezena[d], unidade[d]}), 32'(oldDigits));
                scramble(d);
            end
        end
        req[d] = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL dut%0d ack_missing: got no ack within 200 cycles expected ack at edge %0d", d, e.ackEdge);
            dropExp(d);
        end
    endtask

    // IN request; the button is sampled high from k = pk (relative to E0),
    // optionally held high from before acceptance until k = rel.
    task automatic doIn(input int d, input int pk, input logic [3:0] sw, input bit pre, input int rel);
        exp_t e;
        int   e0;
        int   tmoCyc;
        int   pressAck;
        bit   seen;
        if (pre) begin
            @(negedge clk);
            botao[d] = 1'b1;
        end
        @(negedge clk);
        e0 = cyc;
        req[d] = 1'b1;
        cmd[d] = 2'b01;
        wdata[d] = $urandom;
        switches[d] = sw;
        botao[d] = botaoAt(0, pre, rel, pk);
        // A press is answered on the edge after it is sampled; the timeout
        // fires IN_TIMEOUT+1 edges after acceptance; a tie goes to the press.
        tmoCyc   = (d == 1) ? 8 : 0;
        pressAck = e0 + pk + 1;
        e.c = mC[d]; e.d = mD[d]; e.u = mU[d]; e.ovf = mOvf[d];
        if (tmoCyc > 0 && e0 + tmoCyc + 1 < pressAck) begin
            e.ackEdge = e0 + tmoCyc + 1;
            e.rdata = 32'd0;
            e.tmo = 1'b1;
        end else begin
            e.ackEdge = pressAck;
            e.rdata = {28'd0, sw};
            e.tmo = 1'b0;
        end
        mRdata[d] = e.rdata;
        pushExp(d, e);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (ack[d]) seen = 1'b1;
            else begin
                chk(d, "waiting_in_during_in", 32'(waitingIn[d]), 32'd1);
                chk(d, "busy_during_in", 32'(busy[d]), 32'd1);
                botao[d] = botaoAt(cyc - e0, pre, rel, pk);
                scramble(d);
            end
        end
        req[d] = 1'b0;
        botao[d] = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL dut%0d in_ack_missing: got no ack within 200 cycles expected ack at edge %0d", d, e.ackEdge);
            dropExp(d);
        end
    endtask

    task automatic checkAllZero(input int d, input string tag);
        chk(d, {tag, "_ack"}, 32'(ack[d]), 32'd0);
        chk(d, {tag, "_rdata"}, rdata[d], 32'd0);
        chk(d, {tag, "_busy"}, 32'(busy[d]), 32'd0);
        chk(d, {tag, "_waiting"}, 32'(waitingIn[d]), 32'd0);
        chk(d, {tag, "_timeout"}, 32'(timeoutO[d]), 32'd0);
        chk(d, {tag, "_overflow"}, 32'(overflow[d]), 32'd0);
        chk(d, {tag, "_digits"}, 32'({centena[d], dezena[d], unidade[d]}), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int d;
        int op;
        int sel;
        int rel;
        int pk;
        logic [31:0] v;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; cmd[i] = 2'b00; wdata[i] = '0; botao[i] = 1'b0; switches[i] = '0;
            mRdata[i] = '0; mC[i] = '0; mD[i] = '0; mU[i] = '0; mOvf[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkAllZero(0, "reset");
        checkAllZero(1, "reset");
        reset = 1'b0;

        // IN, press sampled at E5, switches A.
        doIn(0, 5, 4'hA, 1'b0, 0);
        // IN with the button already held: only the second press counts.
        doIn(0, 25, 4'h3, 1'b1, 20);
        // OUT conversions and overflow.
        doReq(0, 2'b10, 32'd472);
        doReq(0, 2'b10, 32'd1000);
        doReq(0, 2'b10, 32'd0);
        // Timeout responder: normal press, no press, press tied with timeout.
        doIn(1, 2, 4'h9, 1'b0, 0);
        doIn(1, 100, 4'h7, 1'b0, 0);
        doIn(1, 8, 4'h6, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                sel = int'($urandom_range(0, 5));
                case (sel)
                    0: v = 32'($urandom_range(0, 999));
                    1: v = 32'd999;
                    2: v = 32'd1000;
                    3: v = $urandom;
                    4: v = 32'd0;
                    default: v = 32'($urandom_range(0, 99));
                endcase
                doReq(d, 2'b10, v);
            end else if (op == 1) begin
                doReq(d, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, $urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                rel = int'($urandom_range(1, 4));
                pk  = rel + 1 + int'($urandom_range(0, 10));
                doIn(d, pk, 4'($urandom), 1'b1, rel);
            end else begin
                doIn(d, int'($urandom_range(0, 14)), 4'($urandom), 1'b0, 0);
            end
        end

        // Give dut0 visible state, then reset it in the middle of an OUT 999.
        doIn(0, 3, 4'h5, 1'b0, 0);
        doReq(0, 2'b10, 32'd123);
        @(negedge clk);
        e0 = cyc;
        req[0] = 1'b1;
        cmd[0] = 2'b10;
        wdata[0] = 32'd999;
        while (cyc < e0 + 5) @(negedge clk);
        reset = 1'b1;
        req[0] = 1'b0;
        @(negedge clk);
        checkAllZero(0, "mid_out_reset");
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mRdata[i] = '0; mC[i] = '0; mD[i] = '0; mU[i] = '0; mOvf[i] = 1'b0;
        end
        repeat (15) @(negedge clk);
        doReq(0, 2'b00, $urandom);

        repeat (5) @(negedge clk);
        chk(0, "queue_drained", 32'(q0.size()), 32'd0);
        chk(1, "queue_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
